// File: rtl/alu_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_operand_stage_pkg
// Brief  : Source-select codes and shared widths for the decode->EX operand
//          stage.
// Rev    : 1.0  initial release
// ============================================================================
package alu_operand_stage_pkg;

   // Register-file index width (x0..x31)
   localparam int REG_ADDR_LEN = 5;

   // Native widths of the selector code spaces below
   localparam int SRCA_CODE_LEN = 1;
   localparam int SRCB_CODE_LEN = 3;

   typedef logic [REG_ADDR_LEN-1:0] reg_addr_t;

   // ALU operand A sources
   localparam logic [SRCA_CODE_LEN-1:0] SRCA_RS1 = 1'b0;
   localparam logic [SRCA_CODE_LEN-1:0] SRCA_PC  = 1'b1;

   // ALU operand B sources; codes 6 and 7 are unassigned and select zero
   localparam logic [SRCB_CODE_LEN-1:0] SRCB_RS2   = 3'd0;
   localparam logic [SRCB_CODE_LEN-1:0] SRCB_IMM_I = 3'd1;
   localparam logic [SRCB_CODE_LEN-1:0] SRCB_IMM_S = 3'd2;
   localparam logic [SRCB_CODE_LEN-1:0] SRCB_IMM_U = 3'd3;
   localparam logic [SRCB_CODE_LEN-1:0] SRCB_IMM_J = 3'd4;
   localparam logic [SRCB_CODE_LEN-1:0] SRCB_FOUR  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/alu_operand_stage_bypass.sv
`default_nettype none
// ============================================================================
// Module : operand_bypass
// Brief  : Priority match of one register read against NUM_FWD in-flight
//          results. Source 0 is the youngest and wins over older sources.
//          x0 never forwards and always reads zero.
// Rev    : 1.0  initial release
// ============================================================================
module operand_bypass
   import alu_operand_stage_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int NUM_FWD = 2
) (
   input  logic [REG_ADDR_LEN-1:0]         addr,
   input  logic [XLEN-1:0]                 reg_data,
   input  logic [NUM_FWD-1:0]              fwd_valid,
   input  logic [NUM_FWD-1:0]              fwd_pend,
   input  logic [NUM_FWD*REG_ADDR_LEN-1:0] fwd_addr,
   input  logic [NUM_FWD*XLEN-1:0]         fwd_data,
   output logic [XLEN-1:0]                 data,
   output logic                            hit,
   output logic                            pend
);

   // Walk oldest->youngest so the lowest matching index is the last to write
   always_comb begin
      data = reg_data;
      hit  = 1'b0;
      pend = 1'b0;
      if (addr == '0) begin
         data = '0;
      end else begin
         for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_valid[k] && (fwd_addr[k*REG_ADDR_LEN +: REG_ADDR_LEN] == addr)) begin
               data = fwd_data[k*XLEN +: XLEN];
               hit  = 1'b1;
               pend = fwd_pend[k];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module : alu_operand_stage
// Brief  : Decode->EX operand stage: ALU source selection with result
//          bypassing, load-use stall, flush, valid/ready EX register and a
//          saturating stall-cycle counter.
// Rev    : 1.0  initial release
// ============================================================================
module alu_operand_stage
   import alu_operand_stage_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int NUM_FWD      = 2,
   parameter int SRCA_SEL_LEN = 1,
   parameter int SRCB_SEL_LEN = 3,
   parameter int CNT_LEN      = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            flush,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [SRCA_SEL_LEN-1:0]         srca_sel,
   input  logic [SRCB_SEL_LEN-1:0]         srcb_sel,
   input  logic [REG_ADDR_LEN-1:0]         rs1_addr,
   input  logic [REG_ADDR_LEN-1:0]         rs2_addr,
   input  logic [XLEN-1:0]                 rs1,
   input  logic [XLEN-1:0]                 rs2,
   input  logic [XLEN-1:0]                 pc,
   input  logic [XLEN-1:0]                 imm_i,
   input  logic [XLEN-1:0]                 imm_s,
   input  logic [XLEN-1:0]                 imm_u,
   input  logic [XLEN-1:0]                 imm_j,
   input  logic [NUM_FWD-1:0]              fwd_valid,
   input  logic [NUM_FWD-1:0]              fwd_pend,
   input  logic [NUM_FWD*REG_ADDR_LEN-1:0] fwd_addr,
   input  logic [NUM_FWD*XLEN-1:0]         fwd_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [XLEN-1:0]                 srca,
   output logic [XLEN-1:0]                 srcb,
   output logic [XLEN-1:0]                 rs2_val,
   output logic [CNT_LEN-1:0]              stall_cnt
);

   logic [XLEN-1:0]    rs1_fwd, rs2_fwd;
   logic               hit1, hit2, pend1, pend2;
   logic               use1, use2, hazard, accept;
   logic [XLEN-1:0]    srca_mux, srcb_mux;

   logic               out_valid_d, out_valid_q;
   logic [XLEN-1:0]    srca_d, srca_q;
   logic [XLEN-1:0]    srcb_d, srcb_q;
   logic [XLEN-1:0]    rs2_val_d, rs2_val_q;
   logic [CNT_LEN-1:0] stall_cnt_d, stall_cnt_q;

   operand_bypass #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_byp_rs1 (
      .addr      (rs1_addr),
      .reg_data  (rs1),
      .fwd_valid (fwd_valid),
      .fwd_pend  (fwd_pend),
      .fwd_addr  (fwd_addr),
      .fwd_data  (fwd_data),
      .data      (rs1_fwd),
      .hit       (hit1),
      .pend      (pend1)
   );

   operand_bypass #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_byp_rs2 (
      .addr      (rs2_addr),
      .reg_data  (rs2),
      .fwd_valid (fwd_valid),
      .fwd_pend  (fwd_pend),
      .fwd_addr  (fwd_addr),
      .fwd_data  (fwd_data),
      .data      (rs2_fwd),
      .hit       (hit2),
      .pend      (pend2)
   );

   // Operand source muxes; unassigned selector codes yield zero
   always_comb begin
      srca_mux = '0;
      srcb_mux = '0;
      case (srca_sel)
         SRCA_RS1: srca_mux = rs1_fwd;
         SRCA_PC:  srca_mux = pc;
         default:  srca_mux = '0;
      endcase
      case (srcb_sel)
         SRCB_RS2:   srcb_mux = rs2_fwd;
         SRCB_IMM_I: srcb_mux = imm_i;
         SRCB_IMM_S: srcb_mux = imm_s;
         SRCB_IMM_U: srcb_mux = imm_u;
         SRCB_IMM_J: srcb_mux = imm_j;
         SRCB_FOUR:  srcb_mux = XLEN'(4);
         default:    srcb_mux = '0;
      endcase
   end

   // Load-use hazard and handshake; a store (IMM_S) still needs rs2 as data
   always_comb begin
      use1     = (srca_sel == SRCA_RS1);
      use2     = (srcb_sel == SRCB_RS2) || (srcb_sel == SRCB_IMM_S);
      hazard   = in_valid && ((use1 && hit1 && pend1) || (use2 && hit2 && pend2));
      in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
      accept   = in_valid && in_ready;
   end

   // Next-state for EX register and stall counter (flush beats everything)
   always_comb begin
      out_valid_d = out_valid_q;
      srca_d      = srca_q;
      srcb_d      = srcb_q;
      rs2_val_d   = rs2_val_q;
      stall_cnt_d = stall_cnt_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         srca_d      = srca_mux;
         srcb_d      = srcb_mux;
         rs2_val_d   = rs2_fwd;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (hazard && !flush && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_LEN'(1);
      end
   end

   // EX pipeline register with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         srca_q      <= '0;
         srcb_q      <= '0;
         rs2_val_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         srca_q      <= srca_d;
         srcb_q      <= srcb_d;
         rs2_val_q   <= rs2_val_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign srca      = srca_q;
   assign srcb      = srcb_q;
   assign rs2_val   = rs2_val_q;
   assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_operand_stage
// Brief  : Directed vector table plus hand sequences for stall, backpressure,
//          flush, async reset and counter saturation.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_operand_stage;

   localparam int XLEN    = 32;
   localparam int NUM_FWD = 2;
   localparam int CNT_LEN = 16;

   localparam logic [31:0] PC_V  = 32'h0000_1000;
   localparam logic [31:0] IMM_I = 32'h0000_0111;
   localparam logic [31:0] IMM_S = 32'h0000_0222;
   localparam logic [31:0] IMM_U = 32'h0000_0333;
   localparam logic [31:0] IMM_J = 32'h0000_0444;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [0:0]            srca_sel;
   logic [2:0]            srcb_sel;
   logic [4:0]            rs1_addr, rs2_addr;
   logic [XLEN-1:0]       rs1, rs2, pc, imm_i, imm_s, imm_u, imm_j;
   logic [NUM_FWD-1:0]    fwd_valid, fwd_pend;
   logic [NUM_FWD*5-1:0]  fwd_addr;
   logic [NUM_FWD*XLEN-1:0] fwd_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [XLEN-1:0]       srca, srcb, rs2_val;
   logic [CNT_LEN-1:0]    stall_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_operand_stage #(
      .XLEN(XLEN), .NUM_FWD(NUM_FWD), .SRCA_SEL_LEN(1), .SRCB_SEL_LEN(3), .CNT_LEN(CNT_LEN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .srca_sel(srca_sel), .srcb_sel(srcb_sel), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1(rs1), .rs2(rs2), .pc(pc), .imm_i(imm_i), .imm_s(imm_s), .imm_u(imm_u),
      .imm_j(imm_j), .fwd_valid(fwd_valid), .fwd_pend(fwd_pend), .fwd_addr(fwd_addr),
      .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready), .srca(srca),
      .srcb(srcb), .rs2_val(rs2_val), .stall_cnt(stall_cnt)
   );

   typedef struct {
      logic [0:0]  asel;
      logic [2:0]  bsel;
      logic [4:0]  a1, a2;
      logic [31:0] r1, r2;
      logic [1:0]  fv;
      logic [4:0]  fa0, fa1;
      logic [31:0] fd0, fd1;
      logic [31:0] ea, eb, er;
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_fwd(input logic [1:0] fv, input logic [1:0] fp,
                            input logic [4:0] fa0, input logic [4:0] fa1,
                            input logic [31:0] fd0, input logic [31:0] fd1);
      fwd_valid = fv;
      fwd_pend  = fp;
      fwd_addr  = {fa1, fa0};
      fwd_data  = {fd1, fd0};
   endtask

   initial begin
      //            asel bsel a1 a2  r1     r2     fv     fa0 fa1 fd0           fd1           ea            eb            er
      vecs[0]  = '{1'b0, 3'd0, 3, 4, 32'h10, 32'h20, 2'b00, 0, 0, 32'h0,        32'h0,        32'h10,       32'h20,       32'h20};
      vecs[1]  = '{1'b1, 3'd1, 3, 4, 32'h10, 32'h20, 2'b00, 0, 0, 32'h0,        32'h0,        PC_V,         IMM_I,        32'h20};
      vecs[2]  = '{1'b0, 3'd2, 3, 4, 32'h10, 32'h20, 2'b00, 0, 0, 32'h0,        32'h0,        32'h10,       IMM_S,        32'h20};
      vecs[3]  = '{1'b0, 3'd3, 3, 4, 32'h10, 32'h20, 2'b01, 3, 0, 32'hAAAA,     32'h0,        32'hAAAA,     IMM_U,        32'h20};
      vecs[4]  = '{1'b1, 3'd4, 3, 4, 32'h10, 32'h20, 2'b10, 0, 4, 32'h0,        32'hBBBB,     PC_V,         IMM_J,        32'hBBBB};
      vecs[5]  = '{1'b0, 3'd5, 0, 4, 32'h0,  32'h20, 2'b01, 0, 0, 32'hFFFF,     32'h0,        32'h0,        32'h4,        32'h20};
      vecs[6]  = '{1'b0, 3'd0, 5, 5, 32'h10, 32'h20, 2'b11, 5, 5, 32'hAAAA,     32'hBBBB,     32'hAAAA,     32'hAAAA,     32'hAAAA};
      vecs[7]  = '{1'b0, 3'd0, 5, 5, 32'h10, 32'h20, 2'b10, 5, 5, 32'hAAAA,     32'hBBBB,     32'hBBBB,     32'hBBBB,     32'hBBBB};
      vecs[8]  = '{1'b0, 3'd6, 3, 4, 32'h10, 32'h20, 2'b00, 0, 0, 32'h0,        32'h0,        32'h10,       32'h0,        32'h20};
      vecs[9]  = '{1'b1, 3'd7, 3, 4, 32'h10, 32'h20, 2'b00, 0, 0, 32'h0,        32'h0,        PC_V,         32'h0,        32'h20};
      vecs[10] = '{1'b0, 3'd0, 3, 4, 32'h10, 32'h20, 2'b11, 7, 3, 32'hCCCC,     32'hBBBB,     32'hBBBB,     32'h20,       32'h20};
      vecs[11] = '{1'b0, 3'd0, 3, 4, 32'h10, 32'h20, 2'b01, 4, 0, 32'hDDDD,     32'h0,        32'h10,       32'hDDDD,     32'hDDDD};
      vecs[12] = '{1'b0, 3'd0, 3, 4, 32'h10, 32'h20, 2'b10, 3, 9, 32'hEEEE,     32'h9999,     32'h10,       32'h20,       32'h20};

      // Quiescent inputs, reset asserted
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      srca_sel = 1'b0; srcb_sel = 3'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
      rs1 = '0; rs2 = '0; pc = PC_V; imm_i = IMM_I; imm_s = IMM_S; imm_u = IMM_U; imm_j = IMM_J;
      drive_fwd(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
      #2;
      chk("reset out_valid", {31'b0, out_valid}, 32'h0);
      chk("reset srca", srca, 32'h0);
      chk("reset srcb", srcb, 32'h0);
      chk("reset rs2_val", rs2_val, 32'h0);
      chk("reset stall_cnt", {16'b0, stall_cnt}, 32'h0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Table: one accept per vector, consumer always ready
      for (int i = 0; i < NVEC; i++) begin
         in_valid = 1'b1;
         srca_sel = vecs[i].asel; srcb_sel = vecs[i].bsel;
         rs1_addr = vecs[i].a1;   rs2_addr = vecs[i].a2;
         rs1 = vecs[i].r1;        rs2 = vecs[i].r2;
         drive_fwd(vecs[i].fv, 2'b00, vecs[i].fa0, vecs[i].fa1, vecs[i].fd0, vecs[i].fd1);
         #1;
         chk($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, 32'h1);
         @(posedge clk); #1;
         chk($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, 32'h1);
         chk($sformatf("vec%0d srca", i), srca, vecs[i].ea);
         chk($sformatf("vec%0d srcb", i), srcb, vecs[i].eb);
         chk($sformatf("vec%0d rs2_val", i), rs2_val, vecs[i].er);
      end

      // Load-use: pending load result matches rs2 used as SRCB_RS2
      srca_sel = 1'b0; rs1_addr = 5'd3; rs1 = 32'h10;
      srcb_sel = 3'd0; rs2_addr = 5'd6; rs2 = 32'h20;
      drive_fwd(2'b01, 2'b01, 5'd6, 5'd0, 32'h6666, 32'h0);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("loaduse in_ready c%0d", c), {31'b0, in_ready}, 32'h0);
         @(posedge clk); #1;
      end
      chk("loaduse stall_cnt", {16'b0, stall_cnt}, 32'd3);
      chk("loaduse bubble out_valid", {31'b0, out_valid}, 32'h0);
      fwd_pend = 2'b00;
      #1;
      chk("loaduse release in_ready", {31'b0, in_ready}, 32'h1);
      @(posedge clk); #1;
      chk("loaduse srcb", srcb, 32'h6666);
      chk("loaduse rs2_val", rs2_val, 32'h6666);
      chk("loaduse stall_cnt hold", {16'b0, stall_cnt}, 32'd3);

      // Backpressure: capture one op, then hold out_ready low for 4 cycles
      drive_fwd(2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
      srca_sel = 1'b1; srcb_sel = 3'd1;
      @(posedge clk); #1;
      chk("bp first srca", srca, PC_V);
      out_ready = 1'b0;
      srca_sel = 1'b0; rs1 = 32'h55; srcb_sel = 3'd0;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("bp in_ready c%0d", c), {31'b0, in_ready}, 32'h0);
         chk($sformatf("bp srca c%0d", c), srca, PC_V);
         chk($sformatf("bp srcb c%0d", c), srcb, IMM_I);
         chk($sformatf("bp out_valid c%0d", c), {31'b0, out_valid}, 32'h1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      chk("bp consume+accept in_ready", {31'b0, in_ready}, 32'h1);
      @(posedge clk); #1;
      chk("bp no-bubble out_valid", {31'b0, out_valid}, 32'h1);
      chk("bp no-bubble srca", srca, 32'h55);
      chk("bp no-bubble srcb", srcb, 32'h20);

      // Flush with a valid op held and a new op offered
      out_ready = 1'b0; flush = 1'b1;
      srca_sel = 1'b1; srcb_sel = 3'd5;
      #1;
      chk("flush in_ready", {31'b0, in_ready}, 32'h0);
      @(posedge clk); #1;
      chk("flush out_valid", {31'b0, out_valid}, 32'h0);
      chk("flush srca held", srca, 32'h55);
      chk("flush srcb held", srcb, 32'h20);
      flush = 1'b0; out_ready = 1'b1;

      // Async reset mid-operation
      @(posedge clk); #1;
      chk("pre-reset srca", srca, PC_V);
      chk("pre-reset srcb", srcb, 32'h4);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset out_valid", {31'b0, out_valid}, 32'h0);
      chk("async reset srca", srca, 32'h0);
      chk("async reset srcb", srcb, 32'h0);
      chk("async reset stall_cnt", {16'b0, stall_cnt}, 32'h0);
      @(posedge clk); #1;
      chk("reset held srca", srca, 32'h0);
      chk("reset held out_valid", {31'b0, out_valid}, 32'h0);
      rst_n = 1'b1;

      // Saturation: hold a load-use hazard for 2^CNT_LEN+2 cycles
      srca_sel = 1'b0; rs1_addr = 5'd3; srcb_sel = 3'd1;
      drive_fwd(2'b01, 2'b01, 5'd3, 5'd0, 32'h0, 32'h0);
      @(posedge clk); #1;
      chk("sat first count", {16'b0, stall_cnt}, 32'd1);
      repeat (65534) @(posedge clk);
      #1;
      chk("sat reach all-ones", {16'b0, stall_cnt}, 32'h0000_FFFF);
      repeat (3) @(posedge clk);
      #1;
      chk("sat no wrap", {16'b0, stall_cnt}, 32'h0000_FFFF);
      chk("sat out_valid", {31'b0, out_valid}, 32'h0);

      in_valid = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
